// File: rtl/if_stage_pkg.sv
// Shared pipeline package: word type, reset/bubble defaults and PC stride.
package if_stage_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
  localparam word_t NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam word_t PC_INC           = 32'd4;

  // A load target is misaligned when its byte offset within the word is non-zero.
  function automatic logic misaligned(logic [1:0] byte_off);
    return byte_off != 2'b00;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: control/data from the pipeline and the results back to it.
interface if_stage_if;
  import if_stage_pkg::*;

  logic  pc_ld;
  logic  pc_inc;
  logic  stall;
  word_t pc_in;
  word_t im_dout;
  word_t pc_out;
  word_t ifid_instr;
  word_t ifid_pc4;
  logic  ifid_valid;
  word_t fetch_cnt;
  logic  misalign;

  // Pipeline control side.
  modport master (
    output pc_ld, pc_inc, stall, pc_in, im_dout,
    input  pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_cnt, misalign
  );

  // Fetch stage side.
  modport slave (
    input  pc_ld, pc_inc, stall, pc_in, im_dout,
    output pc_out, ifid_instr, ifid_pc4, ifid_valid, fetch_cnt, misalign
  );

endinterface

// File: rtl/ifid_reg.sv
// Generic pipeline register: load, hold, or replace with a bubble.
// Priority: reset > bubble > hold > load.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter word_t NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  bubble,
  input  word_t nxt_instr,
  input  word_t nxt_pc4,
  output word_t instr,
  output word_t pc4,
  output logic  valid
);

  // Register update; a bubble keeps pc4 so downstream still sees the last fetch address.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr <= NOP_WORD;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= NOP_WORD;
      valid <= 1'b0;
    end else if (!hold) begin
      instr <= nxt_instr;
      pc4   <= nxt_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, +4 adder, fetch counter, misalign flag
// and the IF/ID pipeline register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter word_t NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  if_stage_if.slave bus
);

  word_t pc_q, pc_d;
  word_t cnt_q, cnt_d;
  logic  mis_q, mis_d;
  word_t pc_plus4;
  logic  bubble;

  // Modulo-2^32 increment; wrap from 0xFFFF_FFFC to 0 is intentional.
  assign pc_plus4 = pc_q + PC_INC;

  // Next-state decode: pc_ld > stall > pc_inc > idle.
  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    mis_d  = mis_q;
    bubble = 1'b0;
    if (bus.pc_ld) begin
      pc_d   = {bus.pc_in[31:2], 2'b00};
      mis_d  = mis_q | misaligned(bus.pc_in[1:0]);
      bubble = 1'b1;
    end else if (bus.stall) begin
      // Hold everything.
    end else if (bus.pc_inc) begin
      pc_d  = pc_plus4;
      cnt_d = cnt_q + 32'd1;
    end else begin
      bubble = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  // Bubble outranks hold inside ifid_reg, so a flush during stall still clears IF/ID.
  ifid_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid_reg (
    .clk       (clk),
    .reset     (reset),
    .hold      (bus.stall),
    .bubble    (bubble),
    .nxt_instr (bus.im_dout),
    .nxt_pc4   (pc_plus4),
    .instr     (bus.ifid_instr),
    .pc4       (bus.ifid_pc4),
    .valid     (bus.ifid_valid)
  );

  assign bus.pc_out    = pc_q;
  assign bus.fetch_cnt = cnt_q;
  assign bus.misalign  = mis_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: vector table plus hand sequences, expected
// state queued on each drive and compared after the following clock edge.
module tb_if_stage;

  typedef struct {
    logic        rst, ld, stl, inc;
    logic [31:0] pin;
    logic [31:0] pc, instr, pc4;
    logic        valid;
    logic [31:0] cnt;
    logic        mis;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vt[$];
  vec_t sb[$];

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: every word is distinct and non-zero near the test addresses.
  function automatic logic [31:0] imem(logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction

  assign bus.im_dout = imem(bus.pc_out);

  function automatic vec_t mk(logic rst, logic ld, logic stl, logic inc, logic [31:0] pin,
                              logic [31:0] pc, logic [31:0] instr, logic [31:0] pc4,
                              logic valid, logic [31:0] cnt, logic mis);
    vec_t v;
    v.rst = rst; v.ld = ld; v.stl = stl; v.inc = inc; v.pin = pin;
    v.pc = pc; v.instr = instr; v.pc4 = pc4; v.valid = valid; v.cnt = cnt; v.mis = mis;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL step %0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare after the edge.
  task automatic apply(vec_t v, int idx);
    vec_t e;
    @(negedge clk);
    reset       = v.rst;
    bus.pc_ld   = v.ld;
    bus.stall   = v.stl;
    bus.pc_inc  = v.inc;
    bus.pc_in   = v.pin;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pc_out",     idx, bus.pc_out,     e.pc);
    chk("ifid_instr", idx, bus.ifid_instr, e.instr);
    chk("ifid_pc4",   idx, bus.ifid_pc4,   e.pc4);
    chk("ifid_valid", idx, {31'd0, bus.ifid_valid}, {31'd0, e.valid});
    chk("fetch_cnt",  idx, bus.fetch_cnt,  e.cnt);
    chk("misalign",   idx, {31'd0, bus.misalign},   {31'd0, e.mis});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; bus.pc_ld = 1'b0; bus.stall = 1'b0; bus.pc_inc = 1'b0; bus.pc_in = '0;

    //        rst ld stl inc pin            pc            instr         pc4           v  cnt mis
    vt.push_back(mk(1,0,0,0,32'h0,         32'h0,        32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h4,        32'h1000_0000,32'h4,        1, 1, 0));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h8,        32'h1000_0004,32'h8,        1, 2, 0));
    vt.push_back(mk(0,0,0,1,32'h0,         32'hC,        32'h1000_0008,32'hC,        1, 3, 0));
    vt.push_back(mk(0,1,0,1,32'h100,       32'h100,      32'h0,        32'hC,        0, 3, 0));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h104,      32'h1000_0100,32'h104,      1, 4, 0));
    vt.push_back(mk(0,0,0,0,32'h0,         32'h104,      32'h0,        32'h104,      0, 4, 0));
    vt.push_back(mk(0,1,0,0,32'h20,        32'h20,       32'h0,        32'h104,      0, 4, 0));
    vt.push_back(mk(0,0,1,1,32'h0,         32'h20,       32'h0,        32'h104,      0, 4, 0));
    vt.push_back(mk(0,0,1,1,32'h0,         32'h20,       32'h0,        32'h104,      0, 4, 0));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h24,       32'h1000_0020,32'h24,       1, 5, 0));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h28,       32'h1000_0024,32'h28,       1, 6, 0));
    vt.push_back(mk(0,0,1,0,32'h0,         32'h28,       32'h1000_0024,32'h28,       1, 6, 0));
    vt.push_back(mk(0,1,1,1,32'h40,        32'h40,       32'h0,        32'h28,       0, 6, 0));
    vt.push_back(mk(0,1,0,0,32'h102,       32'h100,      32'h0,        32'h28,       0, 6, 1));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h104,      32'h1000_0100,32'h104,      1, 7, 1));
    vt.push_back(mk(0,1,0,0,32'hFFFF_FFFC, 32'hFFFF_FFFC,32'h0,        32'h104,      0, 7, 1));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h0,        32'h0FFF_FFFC,32'h0,        1, 8, 1));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h4,        32'h1000_0000,32'h4,        1, 9, 1));
    vt.push_back(mk(1,1,0,1,32'h200,       32'h0,        32'h0,        32'h0,        0, 0, 0));
    vt.push_back(mk(0,0,0,1,32'h0,         32'h4,        32'h1000_0000,32'h4,        1, 1, 0));

    for (int i = 0; i < vt.size(); i++) apply(vt[i], i);

    // Straight-line fetch run continuing from pc=4, cnt=1.
    for (int k = 1; k <= 6; k++) begin
      apply(mk(0, 0, 0, 1, 32'h0, 32'(4 * k + 4), 32'h1000_0000 + 32'(4 * k),
               32'(4 * k + 4), 1, 32'(1 + k), 0), 100 + k);
    end

    // Misaligned load under stall: flush wins, flag sticks through idle until reset.
    apply(mk(0, 1, 1, 0, 32'h0000_0003, 32'h0, 32'h0, 32'h1C, 0, 7, 1), 200);
    apply(mk(0, 0, 0, 0, 32'h0,         32'h0, 32'h0, 32'h1C, 0, 7, 1), 201);
    apply(mk(0, 0, 1, 0, 32'h0,         32'h0, 32'h0, 32'h1C, 0, 7, 1), 202);
    apply(mk(1, 0, 1, 1, 32'h0,         32'h0, 32'h0, 32'h0,  0, 0, 0), 203);
    apply(mk(0, 0, 0, 1, 32'h0,         32'h4, 32'h1000_0000, 32'h4, 1, 1, 0), 204);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
